// File: rtl/ui_pkg.sv
// Shared user-interface definitions: key FSM state encoding and timing helpers
// common to the debouncer and the button event decoder.
package ui_pkg;

  localparam int DEFAULT_CLOCK_FREQ    = 50_000_000;
  localparam int DEFAULT_LONG_PRESS_MS = 1000;
  localparam int DEFAULT_REPEAT_MS     = 200;

  typedef enum logic [1:0] {
    WAIT_REL,
    IDLE,
    PRESSED,
    LONG
  } key_state_t;

  // 64-bit intermediate so 50 MHz * 1000 ms does not overflow.
  function automatic int ms_to_cycles(input longint freq, input longint ms);
    return int'((freq * ms) / 64'sd1000);
  endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced key level into press/release/long-press/auto-repeat pulses
// and a held flag for the time-set logic.
module button_event
  import ui_pkg::*;
#(
  parameter int   CLOCK_FREQ    = DEFAULT_CLOCK_FREQ,
  parameter int   LONG_PRESS_MS = DEFAULT_LONG_PRESS_MS,
  parameter int   REPEAT_MS     = DEFAULT_REPEAT_MS,
  parameter logic PRESS_LEVEL   = 1'b0,
  parameter int   ENABLE_REPEAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_tick,
  output logic release_tick,
  output logic long_tick,
  output logic repeat_tick,
  output logic key_event,
  output logic held
);

  localparam int LONG_CYCLES   = ms_to_cycles(longint'(CLOCK_FREQ), longint'(LONG_PRESS_MS));
  localparam int REPEAT_CYCLES = ms_to_cycles(longint'(CLOCK_FREQ), longint'(REPEAT_MS));
  localparam int MAX_CYCLES    = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W         = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_timing
    $error("button_event: LONG_CYCLES and REPEAT_CYCLES must both be >= 2");
  end

  key_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             pressed;

  assign pressed = (btn_level == PRESS_LEVEL);

  // Release is tested before any threshold so it always wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_REL;
      cnt          <= '0;
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
      key_event    <= 1'b0;
      held         <= 1'b0;
    end else begin
      press_tick   <= 1'b0;
      release_tick <= 1'b0;
      long_tick    <= 1'b0;
      repeat_tick  <= 1'b0;
      key_event    <= 1'b0;
      case (state)
        WAIT_REL: begin
          held <= 1'b0;
          cnt  <= '0;
          if (!pressed) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          cnt <= '0;
          if (pressed) begin
            state      <= PRESSED;
            press_tick <= 1'b1;
            key_event  <= 1'b1;
            held       <= 1'b1;
          end else begin
            held <= 1'b0;
          end
        end
        PRESSED: begin
          if (!pressed) begin
            state        <= IDLE;
            cnt          <= '0;
            release_tick <= 1'b1;
            held         <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state     <= LONG;
            cnt       <= '0;
            long_tick <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          if (!pressed) begin
            state        <= IDLE;
            cnt          <= '0;
            release_tick <= 1'b1;
            held         <= 1'b0;
          end else if (ENABLE_REPEAT == 0) begin
            cnt <= '0;
          end else if (cnt == REPEAT_LAST) begin
            cnt         <= '0;
            repeat_tick <= 1'b1;
            key_event   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= WAIT_REL;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
